// File: rtl/bk_mouse_port.sv
// BK parallel port 177714 in mouse/joystick mode.
// Turns relative PS/2 motion into latched direction-step bits for the BK
// mouse driver, and returns the port read word and the bus reply.
module bk_mouse_port #(
  parameter int THRESH = 4,
  parameter int ACC_W  = 10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_bus,
  input  logic        port_sel,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_ack,
  input  logic [7:0]  joystick,
  input  logic        mouse_data_ready,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic        left_btn,
  input  logic        right_btn,
  output logic        mode_mouse
);

  // Two guard bits so packet add and step correction never wrap before saturation.
  typedef logic signed [ACC_W+1:0] wide_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam int SAT_LIM = 2 ** (ACC_W - 1) - 1;

  logic        mode_q, mode_d;
  logic        enable_q, enable_d;
  logic [3:0]  step_q, step_d;
  logic [1:0]  btn_q, btn_d;
  acc_t        acc_x_q, acc_x_d;
  acc_t        acc_y_q, acc_y_d;
  logic        wr_q;
  logic        ack_q;

  logic        wr;
  logic        wr_edge;
  wide_t       sum_x, sum_y;
  wide_t       thresh_w;
  wide_t       dx_w, dy_w;

  logic        unused_bits;
  assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1]};

  function automatic acc_t sat(input wide_t v);
    if (v > wide_t'(SAT_LIM))       return acc_t'(SAT_LIM);
    else if (v < -wide_t'(SAT_LIM)) return acc_t'(-SAT_LIM);
    else                            return v[ACC_W-1:0];
  endfunction

  assign wr       = bus_stb & port_sel & bus_we & bus_wtbt[0];
  assign wr_edge  = wr & ~wr_q;
  assign thresh_w = wide_t'(THRESH);
  assign dx_w     = {{(ACC_W-7){pointer_dx[8]}}, pointer_dx};
  assign dy_w     = {{(ACC_W-7){pointer_dy[8]}}, pointer_dy};

  // Next-state: mode select, control write, step emission and accumulation.
  always_comb begin
    mode_d   = mode_q;
    enable_d = enable_q;
    step_d   = step_q;
    btn_d    = {right_btn, left_btn};
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    sum_x    = wide_t'(acc_x_q);
    sum_y    = wide_t'(acc_y_q);

    if (mouse_data_ready)       mode_d = 1'b1;
    else if (joystick != 8'h00) mode_d = 1'b0;

    if (wr_edge && !bus_din[3]) begin
      enable_d = 1'b0;
      step_d   = 4'b0000;
      acc_x_d  = '0;
      acc_y_d  = '0;
    end else begin
      if (wr_edge) enable_d = 1'b1;
      // Emission looks at the registered accumulators; its correction
      // is folded into the same sum as any packet arriving this cycle.
      if (enable_q) begin
        if (!step_q[0] && !step_q[2]) begin
          if (acc_y_q >= acc_t'(THRESH)) begin
            step_d[0] = 1'b1;
            sum_y     = sum_y - thresh_w;
          end else if (acc_y_q <= -acc_t'(THRESH)) begin
            step_d[2] = 1'b1;
            sum_y     = sum_y + thresh_w;
          end
        end
        if (!step_q[1] && !step_q[3]) begin
          if (acc_x_q >= acc_t'(THRESH)) begin
            step_d[1] = 1'b1;
            sum_x     = sum_x - thresh_w;
          end else if (acc_x_q <= -acc_t'(THRESH)) begin
            step_d[3] = 1'b1;
            sum_x     = sum_x + thresh_w;
          end
        end
      end
      // A control write in the same cycle drops the packet.
      if (mouse_data_ready && enable_q && !wr_edge) begin
        sum_x = sum_x + dx_w;
        sum_y = sum_y + dy_w;
      end
      acc_x_d = sat(sum_x);
      acc_y_d = sat(sum_y);
    end
  end

  // State registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mode_q   <= 1'b0;
      enable_q <= 1'b0;
      step_q   <= 4'b0000;
      btn_q    <= 2'b00;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      enable_q <= enable_d;
      step_q   <= step_d;
      btn_q    <= btn_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      wr_q     <= wr;
    end
  end

  // Bus reply follows the strobe, sampled on the bus clock enable.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)       ack_q <= 1'b0;
    else if (ce_bus) ack_q <= bus_stb & port_sel;
  end

  // Read word, zero when the port is not selected.
  always_comb begin
    bus_dout = 16'h0000;
    if (port_sel) begin
      if (mode_q) bus_dout = {9'b0, btn_q, 1'b0, step_q};
      else        bus_dout = {8'b0, joystick};
    end
  end

  assign bus_ack    = ack_q;
  assign mode_mouse = mode_q;

endmodule

// File: doc/bk_mouse_port.md
# bk_mouse_port

Bus-side peripheral for the BK parallel port at 177714 in mouse/joystick mode. It consumes the PS/2 mouse decoder's movement packets and the merged joystick byte, and converts relative motion into the latched direction-step bits the BK mouse driver polls. It returns the port read word and the bus reply that the top level ORs into `cpu_din` and `cpu_ack`.

## Interface
Parameters:
- `THRESH`, default 4: accumulated counts per emitted step; valid range 1..255.
- `ACC_W`, default 10: width of each signed axis accumulator; minimum 9.

Ports:
- `clk_sys`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `ce_bus`  in  1: CPU bus clock enable.
- `port_sel`  in  1: port 177714 decode from the CPU.
- `bus_stb`  in  1: bus strobe (DIN or DOUT).
- `bus_we`  in  1: write cycle.
- `bus_wtbt`  in  2: byte-lane enables; `[0]` is the low byte.
- `bus_din`  in  16: CPU write data.
- `bus_dout`  out  16: read data; zero when `port_sel` is 0.
- `bus_ack`  out  1: reply.
- `joystick`  in  8: merged joystick bits.
- `mouse_data_ready`  in  1: one-clock pulse when a new packet is valid.
- `pointer_dx`, `pointer_dy`  in  9 each: two's-complement deltas.
- `left_btn`, `right_btn`  in  1 each: button levels.
- `mode_mouse`  out  1: 1 when mouse mode is active, 0 for joystick.

## Operation
**Mode select (every clock)**
- `joystick != 0` sets `mode_mouse` to 0.
- A `mouse_data_ready` pulse sets `mode_mouse` to 1.
- If both happen in the same cycle, mouse mode wins.

**Control write**
- A write is the rising edge of `wr = bus_stb & port_sel & bus_we & bus_wtbt[0]`, detected against a 1-clock delayed copy of `wr`.
- On the edge, `enable` is loaded from `bus_din[3]`.
- If `bus_din[3]` is 0, `step[3:0]` and both accumulators are also cleared.
- Writes with `bus_wtbt[0]` = 0 are ignored.

**Accumulation**
- Accumulation happens on `mouse_data_ready` when `enable` = 1.
- `accX` is updated to the saturating sum of `accX` and `sext(pointer_dx)`; `accY` is updated the same way from `pointer_dy`.
- Saturation limits are ±(2^(ACC_W-1) - 1).
- Packets that arrive while `enable` = 0 are dropped.

**Step emission (every clock, when `enable` = 1, evaluated on the registered accumulators)**
- Y axis, only when `step[0]` and `step[2]` are both 0:
  - If `accY` ≥ THRESH: set `step[0]` and subtract THRESH from `accY`.
  - Otherwise, if `accY` ≤ -THRESH: set `step[2]` and add THRESH to `accY`.
- X axis: same rule using `step[1]` (positive), `step[3]` (negative) and `accX`.
- Step bits stay set until a write with bit 3 = 0 clears them. Accumulation continues while they are set.
- If an emission subtraction and a packet add fall in the same cycle, both apply; the sum is then saturated.

**Buttons**
- `btn[6:5]` is registered every clock as {`right_btn`, `left_btn`}.

**Read data (combinational from registers)**
- Mouse mode: `{9'b0, btn[6:5], 1'b0, step[3:0]}`.
- Joystick mode: `{8'b0, joystick}`.

**Reply**
- Registered on `ce_bus`: `bus_ack` is loaded with `bus_stb & port_sel`.

**Priority**
- A control write takes precedence over a packet in the same cycle: the write is applied and the packet is dropped.

## Timing
**Reset values**
- `bus_ack` = 0, `mode_mouse` = 0, `enable` = 0.
- `step` = 0, `btn` = 0, `accX` = `accY` = 0.
- The write-edge register is 0.
- `bus_dout` is 0 unless `port_sel` is asserted.

**Latency**
- Packet at clock N: the accumulator updates at edge N+1 and the step bit can set at edge N+2.
- Write: the write-edge detection adds one clock.
- `bus_ack` asserts at the first `ce_bus` after the strobe and deasserts at the first `ce_bus` after the strobe drops.

**Boundaries**
- An asynchronous reset mid-transaction drops `bus_ack` immediately.
- The next strobe is serviced normally.

## Test plan
1. Reset: assert `reset` for 3 clocks with `port_sel` = 1 → `bus_dout` = 0x0000 (joystick mode, `joystick` = 0), `bus_ack` = 0, `mode_mouse` = 0.
2. Mode switch: `joystick` = 0x21 → read 0x0021. Then one `mouse_data_ready` with `left_btn` = 1 → `mode_mouse` = 1 and read 0x0020.
3. Step, THRESH = 4: write 0x0008, then a packet with dy = +5 → `step[0]` = 1 within 2 clocks and `accY` = 1. A further packet with dy = +7 → `step[0]` stays 1, `accY` = 8. Write 0x0000 → read low nibble = 0 and `accY` = 0.
4. Negative X and saturation, ACC_W = 10: enable, hold `step[3]` set, then send 3 packets with dx = -256 (0x100) → `accX` saturates at -511 and `step[1]` stays 0.
5. Collision: a write of 0x0000 in the same clock as a packet with dy = +8 → `accY` = 0 and `step` = 0. A byte write with `bus_wtbt` = 2'b10 → no state change.
6. Reply handshake: hold `bus_stb`/`port_sel` for 40 clocks with `ce_bus` every 24 clocks → `bus_ack` rises at the first `ce_bus` and falls at the first `ce_bus` after the strobe is released.
